// File: rtl/x_serial_tx.sv
// Framed serial transmitter for a 16-bit word: start bit, 16 data bits LSB
// first, even parity bit, stop bit, each held for CLKS_PER_BIT clocks.
module x_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        start,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);

  function automatic logic even_parity(input logic [15:0] word);
    return ^word;
  endfunction

  state_t      state_r;
  logic [15:0] shift_r;
  logic [7:0]  div_r;
  logic [3:0]  bit_r;
  logic        parity_r;
  logic        bit_end_s;

  assign bit_end_s = (div_r == DIV_LAST);

  // Frame sequencer; tx is loaded one bit ahead so it changes exactly on the bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      shift_r  <= 16'd0;
      div_r    <= 8'd0;
      bit_r    <= 4'd0;
      parity_r <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            shift_r  <= in;
            parity_r <= even_parity(in);
            div_r    <= 8'd0;
            bit_r    <= 4'd0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state_r  <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            div_r   <= 8'd0;
            tx      <= shift_r[0];
            state_r <= DATA;
          end else begin
            div_r <= div_r + 8'd1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            div_r   <= 8'd0;
            shift_r <= {1'b0, shift_r[15:1]};
            bit_r   <= bit_r + 4'd1;
            if (bit_r == 4'd15) begin
              tx      <= parity_r;
              state_r <= PARITY;
            end else begin
              tx <= shift_r[1];
            end
          end else begin
            div_r <= div_r + 8'd1;
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            div_r   <= 8'd0;
            tx      <= 1'b1;
            state_r <= STOP;
          end else begin
            div_r <= div_r + 8'd1;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            div_r   <= 8'd0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= IDLE;
          end else begin
            div_r <= div_r + 8'd1;
          end
        end
        default: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
